irq_source_latch: RTL and testbench
===================================

IRQ_SOURCE_LATCH -- requirements
Module: irq_source_latch

Interface
REQ-001 Parameter: IRQ_NUM, default 16, number of request lines (1..16); all vectors below are IRQ_NUM wide.
REQ-002 clk_i  input  1  single clock; all state on rising edge.
REQ-003 rst_ni  input  1  reset, asynchronous assert, active-low.
REQ-004 periph_irq_i  input  IRQ_NUM  raw peripheral interrupt lines, possibly asynchronous to clk_i.
REQ-005 trig_mode_i  input  IRQ_NUM  per-line trigger mode: 1 = rising edge, 0 = level-high.
REQ-006 irq_ret_i  input  IRQ_NUM  one-hot service-complete strobe from the interrupt controller, one cycle.
REQ-007 overrun_clr_i  input  IRQ_NUM  per-line clear strobe for overrun flags.
REQ-008 irq_req_o  output  IRQ_NUM  registered pending requests, fed to the controller irq request input.
REQ-009 overrun_o  output  IRQ_NUM  sticky flag: an edge arrived while the line was already pending.

Function
REQ-010 Per line, the synchronised input s is the second stage of a 2-flop synchronizer (see REQ-026); prev is s delayed one cycle; edge = s & ~prev.
REQ-011 Edge mode: pending next = edge | (pending & ~irq_ret_i[n]).
REQ-012 Edge mode, edge and irq_ret_i[n] in the same cycle: pending stays 1 (new edge wins; no lost request).
REQ-013 Edge mode: irq_ret_i[n] with pending = 0 has no effect.
REQ-014 Level mode: pending next = s; irq_ret_i[n] ignored; overrun never set.
REQ-015 irq_req_o = pending register, no combinational path from any input.
REQ-016 Latency with synchronizer: periph_irq_i rising before clock edge E1 gives irq_req_o = 1 after E3 (3 cycles), both modes.
REQ-017 Clear latency: irq_ret_i[n] sampled at edge E gives irq_req_o[n] = 0 after E (1 cycle), edge mode.
REQ-018 Overrun next = (overrun & ~overrun_clr_i[n]) | (edge & pending & ~irq_ret_i[n]); set wins over clear in the same cycle.
REQ-019 Mode change level->edge: pending keeps its current value and is then cleared only by irq_ret_i.
REQ-020 Mode change edge->level: pending is reloaded from s on the next edge; overrun keeps its value.
REQ-021 Lines are independent; simultaneous events on multiple lines are all captured in the same cycle.
REQ-022 A pulse on periph_irq_i shorter than one clk_i period may be lost; the minimum guaranteed pulse is 2 clk_i periods high and 2 low.

Reset
REQ-023 rst_ni = 0 asynchronously clears synchronizer stages, prev, pending and overrun; irq_req_o = 0, overrun_o = 0.
REQ-024 Reset release: no edge is detected from a line already high at release; the line must fall and rise again in edge mode; level mode asserts after 3 cycles.

Configuration
REQ-025 Macro IRQ_SYNC_EN: defined = 2-flop synchronizer per line, latency per REQ-016; undefined = s = periph_irq_i directly (inputs synchronous to clk_i), assertion latency 1 cycle, clear latency unchanged.

Structure
REQ-026 Sub-module irq_sync: one 2-flop synchronizer, reset per REQ-023, instantiated per line under IRQ_SYNC_EN.
REQ-027 Shared package irq_pkg: IRQ_NUM_MAX = 16, typedef irq_vec_t (logic [15:0]), trigger-mode constants TRIG_LEVEL = 0, TRIG_EDGE = 1.

Verification
REQ-028 Edge mode, line 3: periph_irq_i[3] 0->1 held -> irq_req_o = 16'h0008 after 3 cycles; irq_ret_i = 16'h0008 -> irq_req_o = 0 next cycle, stays 0 while input stays high.
REQ-029 Edge mode, line 0: second rising edge detected in the same cycle as irq_ret_i[0] -> irq_req_o[0] stays 1, overrun_o[0] stays 0.
REQ-030 Edge mode, line 5: two edges 4 cycles apart, no ret -> overrun_o = 16'h0020; overrun_clr_i[5] pulse -> overrun_o = 0 next cycle.
REQ-031 Level mode, line 15: input high 10 cycles -> irq_req_o[15] high cycles 3..12; irq_ret_i[15] mid-window has no effect.
REQ-032 Lines 1 and 2 rise in the same cycle, then rst_ni pulsed low mid-operation -> irq_req_o = 16'h0006, then 0 immediately on reset, and no re-assertion after release while inputs stay high in edge mode.
REQ-033 Build without IRQ_SYNC_EN: repeat REQ-028 -> irq_req_o asserts after 1 cycle.

Source files
------------

// File: rtl/irq_pkg.sv
// Shared definitions for the interrupt source latch: vector width limits,
// the full-width vector type and the per-line trigger-mode encodings.
package irq_pkg;

  // Widest supported request vector.
  localparam int unsigned IRQ_NUM_MAX = 16;

  // Full-width interrupt vector.
  typedef logic [IRQ_NUM_MAX-1:0] irq_vec_t;

  // Per-line trigger-mode encodings as seen on trig_mode_i.
  localparam logic TRIG_LEVEL = 1'b0;
  localparam logic TRIG_EDGE  = 1'b1;

  // Cycles after reset release before the delayed copy of the sampled line
  // holds a genuine sample. Until then edge detection is held off so a line
  // that is already high at release is not mistaken for a fresh edge.
  function automatic logic [1:0] warmup_cycles(input bit sync_en);
    return sync_en ? 2'd3 : 2'd1;
  endfunction

endpackage

// File: rtl/irq_sync.sv
// Two-flop synchronizer for one interrupt line. Both stages clear
// asynchronously on reset so a line never looks high straight out of reset.
module irq_sync (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  // Shift the raw line through two flops to settle metastability.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/irq_source_latch.sv
// Interrupt source latch: turns raw peripheral interrupt lines into
// registered pending requests for the interrupt controller.
//
// Each line is either level-high (request follows the sampled line) or
// rising-edge (request latches on an edge and is released by the controller's
// service-complete strobe). An edge arriving while the line is still pending
// raises a sticky overrun flag that software clears per line.
//
// Build option IRQ_SYNC_EN: when defined, every line passes through a two-flop
// synchronizer (request appears three cycles after the input rises); when
// undefined the lines are assumed synchronous to clk_i and are used directly
// (request appears one cycle after the input rises).
module irq_source_latch
  import irq_pkg::*;
#(
  parameter int unsigned IRQ_NUM = 16
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic [IRQ_NUM-1:0] periph_irq_i,
  input  logic [IRQ_NUM-1:0] trig_mode_i,
  input  logic [IRQ_NUM-1:0] irq_ret_i,
  input  logic [IRQ_NUM-1:0] overrun_clr_i,
  output logic [IRQ_NUM-1:0] irq_req_o,
  output logic [IRQ_NUM-1:0] overrun_o
);

`ifdef IRQ_SYNC_EN
  localparam logic [1:0] WARMUP = warmup_cycles(1'b1);
`else
  localparam logic [1:0] WARMUP = warmup_cycles(1'b0);
`endif

  logic [IRQ_NUM-1:0] line_s;
  logic [IRQ_NUM-1:0] prev_q,    prev_d;
  logic [IRQ_NUM-1:0] pending_q, pending_d;
  logic [IRQ_NUM-1:0] overrun_q, overrun_d;
  logic [IRQ_NUM-1:0] edge_det;
  logic [1:0]         warm_q,    warm_d;
  logic               armed;

`ifdef IRQ_SYNC_EN
  for (genvar g = 0; g < int'(IRQ_NUM); g++) begin : g_sync
    irq_sync u_sync (
      .clk_i  (clk_i),
      .rst_ni (rst_ni),
      .d_i    (periph_irq_i[g]),
      .q_o    (line_s[g])
    );
  end
`else
  assign line_s = periph_irq_i;
`endif

  // Down-count the post-reset warm-up; edges are honoured once it reaches zero.
  always_comb begin
    warm_d = warm_q;
    if (warm_q != 2'd0) begin
      warm_d = warm_q - 2'd1;
    end
  end

  assign armed    = (warm_q == 2'd0);
  assign prev_d   = line_s;
  assign edge_det = line_s & ~prev_q & {IRQ_NUM{armed}};

  // Per-line pending and overrun next-state according to the trigger mode.
  always_comb begin
    pending_d = pending_q;
    overrun_d = overrun_q;
    for (int n = 0; n < int'(IRQ_NUM); n++) begin
      if (trig_mode_i[n] == TRIG_EDGE) begin
        // A new edge wins over a simultaneous service-complete strobe.
        pending_d[n] = edge_det[n] | (pending_q[n] & ~irq_ret_i[n]);
        overrun_d[n] = (overrun_q[n] & ~overrun_clr_i[n])
                     | (edge_det[n] & pending_q[n] & ~irq_ret_i[n]);
      end else begin
        pending_d[n] = line_s[n];
        overrun_d[n] = overrun_q[n] & ~overrun_clr_i[n];
      end
    end
  end

  // State registers; reset clears every line and restarts the warm-up.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      prev_q    <= '0;
      pending_q <= '0;
      overrun_q <= '0;
      warm_q    <= WARMUP;
    end else begin
      prev_q    <= prev_d;
      pending_q <= pending_d;
      overrun_q <= overrun_d;
      warm_q    <= warm_d;
    end
  end

  assign irq_req_o = pending_q;
  assign overrun_o = overrun_q;

endmodule

// File: tb/tb_irq_source_latch.sv
// Directed self-checking bench for irq_source_latch. Expected request latency
// follows the IRQ_SYNC_EN build option (3 cycles synchronised, 1 otherwise).
module tb_irq_source_latch;
  import irq_pkg::*;

`ifdef IRQ_SYNC_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 1;
`endif

  logic     clk_i = 1'b0;
  logic     rst_ni;
  irq_vec_t periph_irq_i;
  irq_vec_t trig_mode_i;
  irq_vec_t irq_ret_i;
  irq_vec_t overrun_clr_i;
  irq_vec_t irq_req_o;
  irq_vec_t overrun_o;

  int n_pass  = 0;
  int n_total = 0;

  irq_source_latch #(.IRQ_NUM(16)) dut (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .periph_irq_i  (periph_irq_i),
    .trig_mode_i   (trig_mode_i),
    .irq_ret_i     (irq_ret_i),
    .overrun_clr_i (overrun_clr_i),
    .irq_req_o     (irq_req_o),
    .overrun_o     (overrun_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk_i);
      #1;
    end
  endtask

  task automatic check(input string tag, input irq_vec_t obs, input irq_vec_t exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  initial begin
    rst_ni        = 1'b0;
    periph_irq_i  = '0;
    trig_mode_i   = 16'h7FFF;
    irq_ret_i     = '0;
    overrun_clr_i = '0;
    #3;
    check("reset_req", irq_req_o, 16'h0000);
    check("reset_ovr", overrun_o, 16'h0000);
    tick(1);
    rst_ni = 1'b1;
    tick(5);

    // Edge mode line 3: assert, service, stay low while input held high.
    periph_irq_i[3] = 1'b1;
    tick(LAT - 1);
    check("l3_before_lat", irq_req_o, 16'h0000);
    tick(1);
    check("l3_asserted", irq_req_o, 16'h0008);
    irq_ret_i = 16'h0008;
    tick(1);
    irq_ret_i = '0;
    check("l3_cleared", irq_req_o, 16'h0000);
    tick(3);
    check("l3_stays_low", irq_req_o, 16'h0000);
    check("l3_no_ovr", overrun_o, 16'h0000);
    periph_irq_i[3] = 1'b0;
    tick(4);

    // Edge mode line 0: new edge coincides with service-complete.
    periph_irq_i[0] = 1'b1;
    tick(LAT);
    check("l0_first", irq_req_o, 16'h0001);
    periph_irq_i[0] = 1'b0;
    tick(2);
    periph_irq_i[0] = 1'b1;
    tick(LAT - 1);
    irq_ret_i = 16'h0001;
    tick(1);
    irq_ret_i = '0;
    check("l0_edge_wins", irq_req_o, 16'h0001);
    check("l0_no_ovr", overrun_o, 16'h0000);
    irq_ret_i = 16'h0001;
    tick(1);
    irq_ret_i = '0;
    check("l0_cleared", irq_req_o, 16'h0000);
    periph_irq_i[0] = 1'b0;
    tick(4);

    // Edge mode line 5: two edges 4 cycles apart without service -> overrun.
    periph_irq_i[5] = 1'b1;
    tick(2);
    periph_irq_i[5] = 1'b0;
    tick(2);
    periph_irq_i[5] = 1'b1;
    tick(LAT);
    check("l5_req", irq_req_o, 16'h0020);
    check("l5_ovr_set", overrun_o, 16'h0020);
    overrun_clr_i = 16'h0020;
    tick(1);
    overrun_clr_i = '0;
    check("l5_ovr_clr", overrun_o, 16'h0000);
    irq_ret_i = 16'h0020;
    tick(1);
    irq_ret_i = '0;
    check("l5_req_clr", irq_req_o, 16'h0000);
    periph_irq_i[5] = 1'b0;
    tick(4);

    // Level mode line 15: high for 10 cycles, service strobe ignored.
    periph_irq_i[15] = 1'b1;
    for (int k = 1; k <= 10 + LAT; k++) begin
      if (k == 5) irq_ret_i = 16'h8000;
      tick(1);
      irq_ret_i = '0;
      check($sformatf("l15_level_k%0d", k), irq_req_o,
            ((k >= LAT) && (k < 10 + LAT)) ? 16'h8000 : 16'h0000);
      if (k == 10) periph_irq_i[15] = 1'b0;
    end
    check("l15_no_ovr", overrun_o, 16'h0000);
    tick(2);

    // Line 15 mode changes: level->edge keeps pending, edge->level reloads.
    periph_irq_i[15] = 1'b1;
    tick(LAT + 1);
    check("l15_level_hi", irq_req_o, 16'h8000);
    trig_mode_i[15] = TRIG_EDGE;
    tick(3);
    check("l15_kept_in_edge", irq_req_o, 16'h8000);
    irq_ret_i = 16'h8000;
    tick(1);
    irq_ret_i = '0;
    check("l15_ret_in_edge", irq_req_o, 16'h0000);
    trig_mode_i[15] = TRIG_LEVEL;
    tick(1);
    check("l15_reload_level", irq_req_o, 16'h8000);
    periph_irq_i[15] = 1'b0;
    tick(LAT + 1);
    check("l15_level_lo", irq_req_o, 16'h0000);

    // Lines 1 and 2 together, then asynchronous reset mid-operation.
    periph_irq_i = 16'h0006;
    tick(LAT);
    check("l12_both", irq_req_o, 16'h0006);
    #2;
    rst_ni = 1'b0;
    #1;
    check("l12_async_rst", irq_req_o, 16'h0000);
    check("l12_async_rst_ovr", overrun_o, 16'h0000);
    tick(1);
    rst_ni = 1'b1;
    tick(8);
    check("l12_no_reassert", irq_req_o, 16'h0000);
    periph_irq_i = '0;
    tick(4);
    periph_irq_i = 16'h0006;
    tick(LAT);
    check("l12_reedge", irq_req_o, 16'h0006);
    irq_ret_i = 16'h0002;
    tick(1);
    irq_ret_i = 16'h0004;
    tick(1);
    irq_ret_i = '0;
    check("l12_ret_both", irq_req_o, 16'h0000);
    periph_irq_i = '0;
    tick(2);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
